// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and helpers for the button event path
package button_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_LOW,
      ST_IDLE,
      ST_PRESSED,
      ST_REPEATING
   } state_e;

   localparam int unsigned EVENT_PULSE_CYCLES = 1;

   // Hold counters never wrap, so they must represent the larger terminal count.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_events.sv
// rtl/button_events.sv - debounced level to press/release/long-press/repeat pulses
module button_events
   import button_pkg::*;
#(
   parameter int unsigned LONG_CYCLES   = 16,
   parameter int unsigned REPEAT_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic level_i,
   output logic press_o,
   output logic release_o,
   output logic long_press_o,
   output logic repeat_o,
   output logic held_o
);

   localparam int unsigned CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
   localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            press_q;
   logic            release_q;
   logic            long_q;
   logic            repeat_q;
   logic            held_q;

   // The state already remembers the previous level, so edge detection lives here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_WAIT_LOW;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         case (state_q)
            ST_WAIT_LOW: begin
               if (!level_i) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end
            end
            ST_IDLE: begin
               if (level_i) begin
                  press_q <= 1'b1;
                  held_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_PRESSED;
               end
            end
            ST_PRESSED: begin
               if (!level_i) begin
                  release_q <= 1'b1;
                  held_q    <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= ST_IDLE;
               end else if (cnt_q == LONG_LAST) begin
                  long_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_REPEATING;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_REPEATING: begin
               // Release takes priority over a repeat due on the same edge.
               if (!level_i) begin
                  release_q <= 1'b1;
                  held_q    <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= ST_IDLE;
               end else if (cnt_q == REPEAT_LAST) begin
                  repeat_q <= 1'b1;
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_WAIT_LOW;
               cnt_q   <= '0;
               held_q  <= 1'b0;
            end
         endcase
      end
   end

   assign press_o      = press_q;
   assign release_o    = release_q;
   assign long_press_o = long_q;
   assign repeat_o     = repeat_q;
   assign held_o       = held_q;

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - scoreboard bench for button_events
module tb_button_events;

   logic clk = 1'b0;
   logic reset_n;
   logic level_i;
   logic press_o, release_o, long_press_o, repeat_o, held_o;

   typedef struct {
      int         sc;
      int         e;
      logic [4:0] v;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   button_events #(.LONG_CYCLES(8), .REPEAT_CYCLES(3)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .level_i      (level_i),
      .press_o      (press_o),
      .release_o    (release_o),
      .long_press_o (long_press_o),
      .repeat_o     (repeat_o),
      .held_o       (held_o)
   );

   function automatic logic [4:0] outs();
      return {press_o, release_o, long_press_o, repeat_o, held_o};
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got {press,release,long,repeat,held}=%b, expected %b", name, act, exp);
      end
   endtask

   // Monitor: every checked edge pops exactly one expected output vector.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check($sformatf("s%0d_e%0d", cur.sc, cur.e), outs(), cur.v);
         check($sformatf("s%0d_e%0d_excl", cur.sc, cur.e),
               {4'b0, $onehot0({press_o, release_o, long_press_o, repeat_o})}, 5'b00001);
      end
   end

   // Called at a negedge; sets level for the next edge and returns at the following negedge.
   task automatic drive(input int sc, input int e, input logic lv,
                        input logic p, input logic r, input logic lp, input logic rp, input logic h);
      exp_t x;
      level_i = lv;
      x.sc = sc;
      x.e  = e;
      x.v  = {p, r, lp, rp, h};
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   task automatic do_reset(input int sc);
      level_i = 1'b0;
      reset_n = 1'b0;
      #1;
      check($sformatf("s%0d_reset", sc), outs(), 5'b0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      level_i = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);

      // Short press: level high for edges 10..12.
      do_reset(1);
      for (int e = 0; e < 20; e++)
         drive(1, e, e >= 10 && e < 13, e == 10, e == 13, 1'b0, 1'b0, e >= 10 && e < 13);

      // Long hold with repeats: level high for edges 10..24.
      do_reset(2);
      for (int e = 0; e < 30; e++)
         drive(2, e, e >= 10 && e < 25, e == 10, e == 25, e == 18, e == 21 || e == 24,
               e >= 10 && e < 25);

      // Drop exactly on the long-press edge: release wins.
      do_reset(3);
      for (int e = 0; e < 23; e++)
         drive(3, e, e >= 10 && e < 18, e == 10, e == 18, 1'b0, 1'b0, e >= 10 && e < 18);

      // Single-cycle pulses back to back.
      do_reset(6);
      for (int e = 0; e < 18; e++)
         drive(6, e, e == 10 || e == 12, e == 10 || e == 12, e == 11 || e == 13, 1'b0, 1'b0,
               e == 10 || e == 12);

      // Reset mid-hold, level held through reset release.
      do_reset(5);
      for (int e = 0; e < 20; e++)
         drive(5, e, e >= 10, e == 10, 1'b0, e == 18, 1'b0, e >= 10);
      reset_n = 1'b0;
      #1;
      check("s5_async_reset", outs(), 5'b0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int e = 0; e < 12; e++)
         drive(4, e, e < 5 || e == 6 || e == 7, e == 6, e == 8, 1'b0, 1'b0, e == 6 || e == 7);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
